// File: rtl/exe_stage_pkg.sv
// Shared bus layouts, alu_op bit indices and divider state encoding for the execute stage.
package exe_stage_pkg;
  localparam int DS_TO_ES_BUS_WD   = 165;
  localparam int ES_TO_MS_BUS_WD   = 77;
  localparam int ES_FWD_BLK_BUS_WD = 39;

  localparam int OP_ADD   = 0;
  localparam int OP_SUB   = 1;
  localparam int OP_SLT   = 2;
  localparam int OP_SLTU  = 3;
  localparam int OP_AND   = 4;
  localparam int OP_NOR   = 5;
  localparam int OP_OR    = 6;
  localparam int OP_XOR   = 7;
  localparam int OP_SLL   = 8;
  localparam int OP_SRL   = 9;
  localparam int OP_SRA   = 10;
  localparam int OP_LUI   = 11;
  localparam int OP_MUL   = 12;
  localparam int OP_MULH  = 13;
  localparam int OP_MULHU = 14;
  localparam int OP_DIV   = 15;
  localparam int OP_DIVU  = 16;
  localparam int OP_MOD   = 17;
  localparam int OP_MODU  = 18;

  // store_op one-hot bit positions
  localparam int ST_B = 0;
  localparam int ST_H = 1;
  localparam int ST_W = 2;

  typedef struct packed {
    logic [18:0] alu_op;
    logic        res_from_mul;
    logic [4:0]  load_op;
    logic [2:0]  store_op;
    logic        src1_is_pc;
    logic        src2_is_imm;
    logic        gr_we;
    logic        mem_we;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic [31:0] rj_value;
    logic [31:0] rkd_value;
    logic [31:0] pc;
  } ds_to_es_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;
endpackage

// File: rtl/exe_stage_div_iter.sv
// Radix-2 restoring divider: one quotient bit per cycle on magnitudes, sign fixups on the way out.
module div_iter
  import exe_stage_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_resetn,
  input  logic         i_start,
  input  logic         i_ack,
  input  logic         i_signed,
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_y,
  output logic         o_done,
  output logic [W-1:0] o_q,
  output logic [W-1:0] o_r
);
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  div_state_t   r_state, w_state_next;
  logic [CW-1:0] r_cnt;
  logic [W-1:0] r_quo, r_rem, r_div;
  logic         r_neg_q, r_neg_r;
  logic [W-1:0] w_x_abs, w_y_abs;
  logic [W:0]   w_trial, w_diff;
  logic         w_ge;

  assign w_x_abs = (i_signed && i_x[W-1]) ? (~i_x + 1'b1) : i_x;
  assign w_y_abs = (i_signed && i_y[W-1]) ? (~i_y + 1'b1) : i_y;

  // Partial remainder stays below the divisor, so the top bit of the difference is a clean borrow flag.
  assign w_trial = {r_rem, r_quo[W-1]};
  assign w_diff  = w_trial - {1'b0, r_div};
  assign w_ge    = ~w_diff[W];

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) r_state <= DIV_IDLE;
    else           r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      DIV_IDLE: if (i_start)            w_state_next = DIV_CALC;
      DIV_CALC: if (r_cnt == CNT_LAST)  w_state_next = DIV_DONE;
      DIV_DONE: if (i_ack)              w_state_next = DIV_IDLE;
      default:                          w_state_next = DIV_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_cnt   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_div   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (r_state == DIV_IDLE && i_start) begin
      r_cnt   <= '0;
      r_quo   <= w_x_abs;
      r_rem   <= '0;
      r_div   <= w_y_abs;
      r_neg_q <= i_signed && (i_x[W-1] ^ i_y[W-1]);
      r_neg_r <= i_signed && i_x[W-1];
    end else if (r_state == DIV_CALC) begin
      r_cnt <= r_cnt + 1'b1;
      r_quo <= {r_quo[W-2:0], w_ge};
      r_rem <= w_ge ? w_diff[W-1:0] : w_trial[W-1:0];
    end
  end

  assign o_done = (r_state == DIV_DONE);
  assign o_q    = r_neg_q ? (~r_quo + 1'b1) : r_quo;
  assign o_r    = r_neg_r ? (~r_rem + 1'b1) : r_rem;
endmodule

// File: rtl/exe_stage.sv
// Execute stage: ALU, multiply, iterative divide, data-SRAM request and forward/block bus to decode.
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter int DIV_W = 32
) (
  input  logic                         i_clk,
  input  logic                         i_resetn,
  input  logic                         i_ms_allowin,
  output logic                         o_es_allowin,
  input  logic                         i_ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0]   i_ds_to_es_bus,
  output logic                         o_es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0]   o_es_to_ms_bus,
  output logic [ES_FWD_BLK_BUS_WD-1:0] o_es_fwd_blk_bus,
  output logic                         o_data_sram_en,
  output logic [3:0]                   o_data_sram_we,
  output logic [31:0]                  o_data_sram_addr,
  output logic [31:0]                  o_data_sram_wdata
);
  logic        r_es_valid;
  ds_to_es_t   r_bus;
  logic        w_ready_go, w_is_div, w_is_mod, w_div_signed, w_div_done, w_is_mul;
  logic        w_is_load, w_is_store, w_slt, w_sltu, w_fwd_we, w_blk_we;
  logic [31:0] w_src1, w_src2, w_alu_res, w_sra, w_mul_res, w_div_q, w_div_r;
  logic [31:0] w_es_result, w_addr;
  logic [63:0] w_mul_a, w_mul_b, w_prod;
  logic [3:0]  w_we;

  assign o_es_allowin     = !r_es_valid || (w_ready_go && i_ms_allowin);
  assign o_es_to_ms_valid = r_es_valid && w_ready_go;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_es_valid <= 1'b0;
      r_bus      <= '0;
    end else begin
      if (o_es_allowin)                    r_es_valid <= i_ds_to_es_valid;
      if (o_es_allowin && i_ds_to_es_valid) r_bus      <= i_ds_to_es_bus;
    end
  end

  assign w_src1 = r_bus.src1_is_pc  ? r_bus.pc  : r_bus.rj_value;
  assign w_src2 = r_bus.src2_is_imm ? r_bus.imm : r_bus.rkd_value;

  assign w_slt  = $signed(w_src1) < $signed(w_src2);
  assign w_sltu = w_src1 < w_src2;
  assign w_sra  = $unsigned($signed(w_src1) >>> w_src2[4:0]);

  assign w_alu_res = ({32{r_bus.alu_op[OP_ADD]}}  & (w_src1 + w_src2))
                   | ({32{r_bus.alu_op[OP_SUB]}}  & (w_src1 - w_src2))
                   | ({32{r_bus.alu_op[OP_SLT]}}  & {31'b0, w_slt})
                   | ({32{r_bus.alu_op[OP_SLTU]}} & {31'b0, w_sltu})
                   | ({32{r_bus.alu_op[OP_AND]}}  & (w_src1 & w_src2))
                   | ({32{r_bus.alu_op[OP_NOR]}}  & ~(w_src1 | w_src2))
                   | ({32{r_bus.alu_op[OP_OR]}}   & (w_src1 | w_src2))
                   | ({32{r_bus.alu_op[OP_XOR]}}  & (w_src1 ^ w_src2))
                   | ({32{r_bus.alu_op[OP_SLL]}}  & (w_src1 << w_src2[4:0]))
                   | ({32{r_bus.alu_op[OP_SRL]}}  & (w_src1 >> w_src2[4:0]))
                   | ({32{r_bus.alu_op[OP_SRA]}}  & w_sra)
                   | ({32{r_bus.alu_op[OP_LUI]}}  & w_src2);

  // 33-bit extended operands widened to 64; the low 64 product bits hold both high-word variants.
  assign w_mul_a   = {{32{!r_bus.alu_op[OP_MULHU] && w_src1[31]}}, w_src1};
  assign w_mul_b   = {{32{!r_bus.alu_op[OP_MULHU] && w_src2[31]}}, w_src2};
  assign w_prod    = w_mul_a * w_mul_b;
  assign w_mul_res = r_bus.alu_op[OP_MUL] ? w_prod[31:0] : w_prod[63:32];
  assign w_is_mul  = r_bus.res_from_mul || (|r_bus.alu_op[OP_MULHU:OP_MUL]);

  assign w_is_div     = r_bus.alu_op[OP_DIV] | r_bus.alu_op[OP_DIVU] | r_bus.alu_op[OP_MOD] | r_bus.alu_op[OP_MODU];
  assign w_is_mod     = r_bus.alu_op[OP_MOD] | r_bus.alu_op[OP_MODU];
  assign w_div_signed = r_bus.alu_op[OP_DIV] | r_bus.alu_op[OP_MOD];
  assign w_ready_go   = !w_is_div || w_div_done;

  div_iter #(.W(DIV_W)) u_div (
    .i_clk    (i_clk),
    .i_resetn (i_resetn),
    .i_start  (r_es_valid && w_is_div),
    .i_ack    (o_es_to_ms_valid && i_ms_allowin),
    .i_signed (w_div_signed),
    .i_x      (r_bus.rj_value),
    .i_y      (r_bus.rkd_value),
    .o_done   (w_div_done),
    .o_q      (w_div_q),
    .o_r      (w_div_r)
  );

  assign w_es_result = w_is_div ? (w_is_mod ? w_div_r : w_div_q)
                     : w_is_mul ? w_mul_res : w_alu_res;

  assign w_addr     = r_bus.rj_value + r_bus.imm;
  assign w_is_load  = |r_bus.load_op;
  assign w_is_store = r_bus.mem_we && (|r_bus.store_op);

  always_comb begin
    w_we = 4'b0000;
    if (r_es_valid && w_is_store) begin
      if (r_bus.store_op[ST_W])      w_we = 4'b1111;
      else if (r_bus.store_op[ST_H]) w_we = 4'b0011 << {w_addr[1], 1'b0};
      else                           w_we = 4'b0001 << w_addr[1:0];
    end
  end

  assign o_data_sram_en    = r_es_valid && (w_is_load || w_is_store) && i_ms_allowin;
  assign o_data_sram_we    = w_we;
  assign o_data_sram_addr  = w_addr;
  assign o_data_sram_wdata = r_bus.store_op[ST_B] ? {4{r_bus.rkd_value[7:0]}}
                           : r_bus.store_op[ST_H] ? {2{r_bus.rkd_value[15:0]}}
                           : r_bus.rkd_value;

  assign w_fwd_we = r_es_valid && r_bus.gr_we && !w_is_load && w_ready_go;
  assign w_blk_we = r_es_valid && r_bus.gr_we && (w_is_load || !w_ready_go);

  assign o_es_fwd_blk_bus = {w_fwd_we, w_blk_we, r_bus.dest, w_es_result};
  assign o_es_to_ms_bus   = {r_bus.load_op, r_bus.gr_we, r_bus.dest, w_addr[1:0], w_es_result, r_bus.pc};
endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage with an arithmetic reference model checked every cycle.
module tb_exe_stage;
  import exe_stage_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ms_allowin = 1'b1;
  logic        ds_valid = 1'b0;
  ds_to_es_t   ds_bus = '0;
  logic        es_allowin, es_to_ms_valid, sram_en;
  logic [76:0] es_to_ms_bus;
  logic [38:0] fwd_bus;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr, sram_wdata;

  int checks = 0;
  int failures = 0;

  exe_stage dut (
    .i_clk            (clk),
    .i_resetn         (resetn),
    .i_ms_allowin     (ms_allowin),
    .o_es_allowin     (es_allowin),
    .i_ds_to_es_valid (ds_valid),
    .i_ds_to_es_bus   (ds_bus),
    .o_es_to_ms_valid (es_to_ms_valid),
    .o_es_to_ms_bus   (es_to_ms_bus),
    .o_es_fwd_blk_bus (fwd_bus),
    .o_data_sram_en   (sram_en),
    .o_data_sram_we   (sram_we),
    .o_data_sram_addr (sram_addr),
    .o_data_sram_wdata(sram_wdata)
  );

  always #5 clk = ~clk;

  wire        fwd_we    = fwd_bus[38];
  wire        blk_we    = fwd_bus[37];
  wire [4:0]  fwd_waddr = fwd_bus[36:32];
  wire [31:0] fwd_wdata = fwd_bus[31:0];
  wire [31:0] ms_result = es_to_ms_bus[63:32];
  wire [1:0]  ms_addr_lo = es_to_ms_bus[65:64];
  wire [44:0] ms_ctrl   = {es_to_ms_bus[76:64], es_to_ms_bus[31:0]};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Reference result computed directly from the instruction semantics.
  function automatic logic [31:0] model_result(input ds_to_es_t b);
    logic [31:0] a, c, x, y;
    longint      ps;
    logic [63:0] pu;
    logic        sgn;
    a = b.src1_is_pc ? b.pc : b.rj_value;
    c = b.src2_is_imm ? b.imm : b.rkd_value;
    x = b.rj_value;
    y = b.rkd_value;
    sgn = b.alu_op[OP_DIV] || b.alu_op[OP_MOD];
    if (|b.alu_op[18:15]) begin
      if (y == 0) begin
        if (b.alu_op[OP_MOD] || b.alu_op[OP_MODU]) return x;
        return (sgn && x[31]) ? 32'h1 : 32'hFFFF_FFFF;
      end
      if (b.alu_op[OP_DIV])  return $signed(x) / $signed(y);
      if (b.alu_op[OP_MOD])  return $signed(x) % $signed(y);
      if (b.alu_op[OP_DIVU]) return x / y;
      return x % y;
    end
    ps = longint'($signed(a)) * longint'($signed(c));
    pu = {32'b0, a} * {32'b0, c};
    if (b.alu_op[OP_MUL])   return ps[31:0];
    if (b.alu_op[OP_MULH])  return ps[63:32];
    if (b.alu_op[OP_MULHU]) return pu[63:32];
    if (b.alu_op[OP_ADD])   return a + c;
    if (b.alu_op[OP_SUB])   return a - c;
    if (b.alu_op[OP_SLT])   return ($signed(a) < $signed(c)) ? 32'd1 : 32'd0;
    if (b.alu_op[OP_SLTU])  return (a < c) ? 32'd1 : 32'd0;
    if (b.alu_op[OP_AND])   return a & c;
    if (b.alu_op[OP_NOR])   return ~(a | c);
    if (b.alu_op[OP_OR])    return a | c;
    if (b.alu_op[OP_XOR])   return a ^ c;
    if (b.alu_op[OP_SLL])   return a << c[4:0];
    if (b.alu_op[OP_SRL])   return a >> c[4:0];
    if (b.alu_op[OP_SRA])   return $signed(a) >>> c[4:0];
    return c;
  endfunction

  function automatic logic [3:0] model_we(input ds_to_es_t b);
    logic [31:0] ad;
    ad = b.rj_value + b.imm;
    if (!(b.mem_we && |b.store_op)) return 4'h0;
    if (b.store_op[ST_W]) return 4'hF;
    if (b.store_op[ST_H]) return ad[1] ? 4'hC : 4'h3;
    case (ad[1:0])
      2'd0: return 4'h1;
      2'd1: return 4'h2;
      2'd2: return 4'h4;
      default: return 4'h8;
    endcase
  endfunction

  // Scoreboard: instructions resident in ES, and how long the head has been there.
  ds_to_es_t q[$];
  int age = 0;

  always @(negedge clk) begin
    if (!resetn) begin
      q.delete();
      age = 0;
      chk("rst_allowin", es_allowin, 1);
      chk("rst_to_ms_valid", es_to_ms_valid, 0);
      chk("rst_sram_en", sram_en, 0);
      chk("rst_fwd_blk", {fwd_we, blk_we}, 0);
    end else begin
      if (q.size() == 0) begin
        chk("idle_to_ms_valid", es_to_ms_valid, 0);
        chk("idle_allowin", es_allowin, 1);
        chk("idle_sram", {sram_en, sram_we}, 0);
        chk("idle_fwd_blk", {fwd_we, blk_we}, 0);
      end else begin
        ds_to_es_t   cur;
        logic        isdiv, ready, ld, st;
        logic [31:0] ad, res;
        cur   = q[0];
        isdiv = |cur.alu_op[18:15];
        ready = !isdiv || (age >= 33);
        ld    = |cur.load_op;
        st    = cur.mem_we && |cur.store_op;
        ad    = cur.rj_value + cur.imm;
        res   = model_result(cur);
        chk("m_to_ms_valid", es_to_ms_valid, ready);
        chk("m_allowin", es_allowin, ready && ms_allowin);
        chk("m_sram_en", sram_en, (ld || st) && ms_allowin);
        chk("m_sram_we", sram_we, model_we(cur));
        if (ld || st) chk("m_sram_addr", sram_addr, ad);
        chk("m_fwd_we", fwd_we, cur.gr_we && !ld && ready);
        chk("m_blk_we", blk_we, cur.gr_we && (ld || !ready));
        if (cur.gr_we) chk("m_waddr", fwd_waddr, cur.dest);
        if (cur.gr_we && !ld && ready) chk("m_fwd_wdata", fwd_wdata, res);
        if (ready) begin
          chk("m_ms_result", ms_result, res);
          chk("m_ms_ctrl", ms_ctrl, {cur.load_op, cur.gr_we, cur.dest, ad[1:0], cur.pc});
        end
        if (ready && ms_allowin) begin
          void'(q.pop_front());
          age = 0;
        end else begin
          age++;
        end
      end
      if (ds_valid && es_allowin) q.push_back(ds_bus);
    end
  end

  function automatic ds_to_es_t mk(input int op, input logic [31:0] rj, input logic [31:0] rk,
                                   input logic [4:0] dest);
    ds_to_es_t b;
    b = '0;
    b.alu_op[op]   = 1'b1;
    b.res_from_mul = (op >= OP_MUL) && (op <= OP_MULHU);
    b.rj_value     = rj;
    b.rkd_value    = rk;
    b.dest         = dest;
    b.gr_we        = 1'b1;
    b.pc           = 32'h1C00_0000 + 32'(op * 4);
    return b;
  endfunction

  task automatic send(input ds_to_es_t b);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    ds_valid = 1'b1;
    ds_bus   = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (es_allowin) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    ds_valid = 1'b0;
  endtask

  task automatic run_div(input string name, input ds_to_es_t b, input logic [31:0] exp);
    int  stall;
    bit  blk_ok, hold_ok;
    stall = 0; blk_ok = 1; hold_ok = 1;
    send(b);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (es_to_ms_valid) break;
      stall++;
      if (!blk_we) blk_ok = 0;
      if (es_allowin) hold_ok = 0;
    end
    chk({name, "_stall"}, stall, 33);
    chk({name, "_blk_we"}, blk_ok, 1);
    chk({name, "_allowin_low"}, hold_ok, 1);
    chk({name, "_result"}, ms_result, exp);
  endtask

  localparam int NT = 13;
  int          t_op [NT] = '{OP_SUB, OP_SLT, OP_SLTU, OP_AND, OP_NOR, OP_OR, OP_XOR,
                             OP_SLL, OP_SRL, OP_SRA, OP_LUI, OP_MUL, OP_MULH};
  logic [31:0] t_a  [NT] = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hF0F0, 32'h0, 32'hF0, 32'hFF,
                             32'h1, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] t_b  [NT] = '{32'd7, 32'h1, 32'h1, 32'hFF00, 32'h0, 32'h0F, 32'h0F,
                             32'h24, 32'd31, 32'd4, 32'h1234_5000, 32'd3, 32'd3};
  logic [31:0] t_exp[NT] = '{32'hFFFF_FFFE, 32'h1, 32'h0, 32'hF000, 32'hFFFF_FFFF, 32'hFF, 32'hF0,
                             32'h10, 32'h1, 32'hF800_0000, 32'h1234_5000, 32'hFFFF_FFFD, 32'hFFFF_FFFF};

  initial begin
    ds_to_es_t b;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    b = mk(OP_ADD, 32'd5, 32'd0, 5'd4);
    b.src2_is_imm = 1'b1;
    b.imm = 32'd7;
    send(b);
    @(negedge clk);
    chk("addi_wdata", fwd_wdata, 32'd12);
    chk("addi_fwd_we", fwd_we, 1);
    chk("addi_waddr", fwd_waddr, 4);
    chk("addi_to_ms_valid", es_to_ms_valid, 1);

    run_div("div_w", mk(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd6), 32'hFFFF_FFFD);
    run_div("mod_w", mk(OP_MOD, 32'hFFFF_FFF9, 32'd2, 5'd6), 32'hFFFF_FFFF);

    b = mk(OP_ADD, 32'h1000, 32'h12AB, 5'd0);
    b.gr_we = 1'b0; b.mem_we = 1'b1; b.store_op = 3'b001; b.imm = 32'd3; b.src2_is_imm = 1'b1;
    send(b);
    @(negedge clk);
    chk("stb_addr", sram_addr, 32'h1003);
    chk("stb_we", sram_we, 4'b1000);
    chk("stb_wdata", sram_wdata, 32'hABAB_ABAB);
    chk("stb_en", sram_en, 1);
    b.store_op = 3'b010; b.imm = 32'd2;
    send(b);
    @(negedge clk);
    chk("sth_we", sram_we, 4'b1100);
    chk("sth_wdata", sram_wdata, 32'h12AB_12AB);

    b = mk(OP_ADD, 32'h2000, 32'h0, 5'd5);
    b.load_op = 5'b00100; b.imm = 32'd5; b.src2_is_imm = 1'b1;
    send(b);
    @(negedge clk);
    chk("ldw_en", sram_en, 1);
    chk("ldw_we", sram_we, 0);
    chk("ldw_blk_fwd", {blk_we, fwd_we}, 2'b10);
    chk("ldw_addr_lo", ms_addr_lo, 2'd1);
    send(b);
    ms_allowin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ldw_stall_en", sram_en, 0);
      chk("ldw_stall_allowin", es_allowin, 0);
      chk("ldw_stall_result", ms_result, 32'h2005);
      chk("ldw_stall_pc", es_to_ms_bus[31:0], 32'h1C00_0000);
    end
    @(posedge clk); #1 ms_allowin = 1'b1;

    run_div("divwu_zero", mk(OP_DIVU, 32'h1234, 32'd0, 5'd8), 32'hFFFF_FFFF);
    send(mk(OP_MULHU, 32'hFFFF_FFFF, 32'd2, 5'd9));
    @(negedge clk);
    chk("mulhu_no_stall", es_to_ms_valid, 1);
    chk("mulhu_result", fwd_wdata, 32'h1);

    for (int i = 0; i < NT; i++) begin
      send(mk(t_op[i], t_a[i], t_b[i], 5'd10));
      @(negedge clk);
      chk($sformatf("alu_op%0d", t_op[i]), fwd_wdata, t_exp[i]);
    end
    b = mk(OP_ADD, 32'h0, 32'h0, 5'd11);
    b.src1_is_pc = 1'b1; b.pc = 32'h1C00_0010; b.src2_is_imm = 1'b1; b.imm = 32'd4;
    send(b);
    @(negedge clk);
    chk("pc_plus_imm", fwd_wdata, 32'h1C00_0014);

    send(mk(OP_DIV, 32'd100, 32'd7, 5'd12));
    repeat (10) @(negedge clk);
    chk("middiv_busy", {blk_we, es_to_ms_valid}, 2'b10);
    @(posedge clk); #3 resetn = 1'b0;
    #1;
    chk("async_rst_to_ms_valid", es_to_ms_valid, 0);
    chk("async_rst_allowin", es_allowin, 1);
    chk("async_rst_blk_we", blk_we, 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    send(mk(OP_ADD, 32'd3, 32'd4, 5'd7));
    @(negedge clk);
    chk("post_rst_add", fwd_wdata, 32'd7);
    chk("post_rst_valid", es_to_ms_valid, 1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end
endmodule
